// File: rtl/fib_arbiter.sv
// Round-robin front end sharing one fibonacci core among N_REQ requesters.
// One transaction in flight; responses come back tagged with the requester id.
module fib_arbiter #(
  parameter int N_REQ       = 4,
  parameter int W           = 32,
  parameter int WAIT_CYCLES = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_n,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [W-1:0]       rsp_result,
  output logic               busy,
  output logic               core_start,
  output logic [W-1:0]       core_n,
  input  logic [W-1:0]       core_result,
  input  logic               core_busy
);

  // The start cycle itself can never show busy, so allow one extra cycle.
  localparam int TMO   = WAIT_CYCLES + 1;
  localparam int CNT_W = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ID_W-1:0]  r_rr;
  logic [ID_W-1:0]  r_cur_id;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_req_ready;
  logic             r_core_start;
  logic [W-1:0]     r_core_n;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [W-1:0]     r_rsp_result;

  logic [ID_W-1:0]  w_idx [N_REQ];
  logic [W-1:0]     w_req_n [N_REQ];
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_rr_next;
  logic             w_found;
  logic             w_grant;
  logic             w_cnt_inc;
  logic             w_done_entry;

  // Scan from the pointer downward in priority so the nearest index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx[k]   = ID_W'((int'(r_rr) + k) % N_REQ);
      w_req_n[k] = req_n[k*W +: W];
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_idx[k]]) begin
        w_found = 1'b1;
        w_win   = w_idx[k];
      end
    end
  end

  assign w_rr_next = (w_win == ID_W'(N_REQ - 1)) ?
                     '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_found) w_next = S_WAIT;
      S_WAIT: begin
        if (core_busy)                    w_next = S_RUN;
        else if (r_cnt == CNT_W'(TMO))    w_next = S_DONE;
      end
      S_RUN:  if (!core_busy) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant      = (r_state == S_IDLE) && w_found;
    w_cnt_inc    = (r_state == S_WAIT) && !core_busy;
    w_done_entry = (w_next == S_DONE) && (r_state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr         <= '0;
      r_cur_id     <= '0;
      r_cnt        <= '0;
      r_req_ready  <= '0;
      r_core_start <= 1'b0;
      r_core_n     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else begin
      r_req_ready  <= '0;
      r_core_start <= 1'b0;
      r_rsp_valid  <= 1'b0;
      if (w_grant) begin
        r_req_ready[w_win] <= 1'b1;
        r_core_start       <= 1'b1;
        r_core_n           <= w_req_n[w_win];
        r_cur_id           <= w_win;
        r_rr               <= w_rr_next;
        r_cnt              <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done_entry) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_cur_id;
        r_rsp_result <= core_result;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign core_start = r_core_start;
  assign core_n     = r_core_n;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fib_arbiter.sv
// Bench for fib_arbiter: stub core, event-time model, literal response queue.
// Inputs change #1 after posedge; outputs compared on the falling edge.
module tb_fib_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;
  localparam int WC = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_n;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_result;
  logic           busy;
  logic           core_start;
  logic [W-1:0]   core_n;
  logic [W-1:0]   core_result;
  logic           core_busy;

  always #5 clk = ~clk;

  fib_arbiter #(
    .N_REQ(N), .W(W), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_n(req_n),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy),
    .core_start(core_start), .core_n(core_n),
    .core_result(core_result), .core_busy(core_busy)
  );

  function automatic logic [W-1:0] fib(input logic [W-1:0] n);
    logic [W-1:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // stub core: busy for busy_len cycles after start, or never when stuck
  logic       sb;
  int         scnt;
  logic [W-1:0] sres;
  int         busy_len;
  bit         stuck;
  assign core_busy   = sb;
  assign core_result = sres;

  always @(posedge clk) begin
    if (rst) begin
      sb   <= 1'b0;
      scnt <= 0;
    end else if (core_start) begin
      sres <= stuck ? 32'd42 : fib(core_n);
      if (!stuck) begin
        sb   <= 1'b1;
        scnt <= busy_len;
      end
    end else if (sb) begin
      if (scnt <= 1) sb <= 1'b0;
      else           scnt <= scnt - 1;
    end
  end

  typedef struct {
    int           id;
    logic [W-1:0] res;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nstarts = 0;
  int last_start = 0;

  logic [N-1:0] e_ready = '0;
  logic         e_start = 1'b0;
  logic         e_busy  = 1'b0;
  logic         e_rsp   = 1'b0;
  int           e_id    = 0;
  logic [W-1:0] e_res   = '0;
  logic [W-1:0] e_cn    = '0;
  bit           m_inflight = 1'b0;
  int           m_rr = 0;
  int           m_id = 0;
  logic [W-1:0] m_n  = '0;
  int           m_rsp_at = 0;

  int           rem [N];
  logic [W-1:0] nv  [N];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_and_predict();
    int w;
    exp_t e;
    chk("req_ready", W'(req_ready), W'(e_ready));
    chk("core_start", W'(core_start), W'(e_start));
    chk("busy", W'(busy), W'(e_busy));
    chk("rsp_valid", W'(rsp_valid), W'(e_rsp));
    chk("core_n", core_n, e_cn);
    chk("rsp_id", W'(rsp_id), W'(e_id));
    chk("rsp_result", rsp_result, e_res);
    if (core_start === 1'b1) begin
      nstarts++;
      last_start = cyc;
    end
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected cyc=%0d got id=%0d want none",
                 cyc, rsp_id);
      end else begin
        e = exp_q.pop_front();
        chk("lit_id", W'(rsp_id), W'(e.id));
        chk("lit_result", rsp_result, e.res);
        if (stuck) chk("timeout_latency", W'(cyc - last_start), 32'd6);
      end
    end
    // expectations for the next cycle
    e_ready = '0;
    e_start = 1'b0;
    e_rsp   = 1'b0;
    if (rst) begin
      m_inflight = 1'b0;
      m_rr  = 0;
      e_busy = 1'b0;
      e_id  = 0;
      e_res = '0;
      e_cn  = '0;
    end else if (!m_inflight) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
      if (w >= 0) begin
        e_ready[w] = 1'b1;
        e_start = 1'b1;
        e_busy  = 1'b1;
        m_n  = req_n[w*W +: W];
        e_cn = m_n;
        m_id = w;
        m_rr = (w + 1) % N;
        m_inflight = 1'b1;
        m_rsp_at = cyc + 1 + (stuck ? WC + 2 : busy_len + 2);
      end else begin
        e_busy = 1'b0;
      end
    end else if (cyc == m_rsp_at) begin
      m_inflight = 1'b0;
      e_busy = 1'b0;
    end else begin
      e_busy = 1'b1;
      if (cyc + 1 == m_rsp_at) begin
        e_rsp = 1'b1;
        e_id  = m_id;
        e_res = stuck ? 32'd42 : fib(m_n);
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rem[i] > 0);
      req_n[i*W +: W] = nv[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_and_predict();
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1 && rem[i] > 0) rem[i]--;
    apply();
  endtask

  task automatic post(input int id, input logic [W-1:0] n, input int cnt);
    nv[id]  = n;
    rem[id] = cnt;
    apply();
  endtask

  task automatic push(input int id, input logic [W-1:0] res);
    exp_t e;
    e.id  = id;
    e.res = res;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      tick();
      n++;
      idle = (exp_q.size() == 0) && (busy === 1'b0) && !m_inflight;
      for (int i = 0; i < N; i++) if (rem[i] > 0) idle = 1'b0;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL wait_done cyc=%0d timed out after %0d cycles",
               cyc, budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_core_busy();
    int n;
    n = 0;
    while (sb !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("core_busy_seen", W'(sb), 32'd1);
  endtask

  int s0;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_n = '0;
    stuck = 1'b0;
    busy_len = 3;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      nv[i]  = '0;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single requester
    push(0, 32'd55);
    post(0, 32'd10, 1);
    wait_done(60);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // all four at once from pointer 0
    push(0, 32'd55);
    push(1, 32'd610);
    push(2, 32'd1);
    push(3, 32'd1);
    post(0, 32'd10, 1);
    post(1, 32'd15, 1);
    post(2, 32'd1, 1);
    post(3, 32'd2, 1);
    wait_done(200);

    // ids 1 and 3 held for four transactions
    s0 = nstarts;
    push(1, 32'd610);
    push(3, 32'd610);
    push(1, 32'd610);
    push(3, 32'd610);
    post(1, 32'd15, 2);
    post(3, 32'd15, 2);
    wait_done(200);
    chk("start_count", W'(nstarts - s0), 32'd4);

    // id 2 arrives during RUN and must wait
    busy_len = 6;
    push(0, 32'd55);
    push(2, 32'd1);
    post(0, 32'd10, 1);
    wait_core_busy();
    post(2, 32'd1, 1);
    wait_done(100);

    // reset mid-run drops the job; then id 3 alone from pointer 0
    post(0, 32'd10, 1);
    wait_core_busy();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", W'(busy), 32'd0);
    chk("rst_rsp_valid", W'(rsp_valid), 32'd0);
    chk("rst_core_n", core_n, 32'd0);
    busy_len = 2;
    push(3, 32'd1);
    post(3, 32'd2, 1);
    wait_done(60);

    // core never raises busy
    stuck = 1'b1;
    push(1, 32'd42);
    post(1, 32'd7, 1);
    wait_done(60);
    stuck = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
